// File: rtl/phaser_out_tap_pkg.sv
// Purpose: shared types and constants for the PHASER_OUT tap-control sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package phaser_out_tap_pkg;

    localparam int TAP_W = 6;
    localparam int CNT_W = 9;
    localparam int TMR_W = 9;
    localparam logic [TAP_W-1:0] TAP_MAX = 6'd63;

    typedef enum logic [1:0] {
        CMD_FINE   = 2'd0,
        CMD_COARSE = 2'd1,
        CMD_LOAD   = 2'd2,
        CMD_READ   = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    // True when one more step in direction inc keeps the tap inside 0..TAP_MAX.
    function automatic logic step_ok(input logic [TAP_W-1:0] tap, input logic inc);
        return inc ? (tap != TAP_MAX) : (tap != '0);
    endfunction

endpackage

// File: rtl/phaser_out_settle_timer.sv
// Purpose: loadable down-counter used for inter-step settling and counter-read waits.
// Latency: done is high in the load_val-th cycle after the load edge (load_val >= 1).
// Backpressure: none; a load always restarts the count.
// Ports: clk, rst (sync, active-high), load + load_val start a wait, done flags expiry.
module phaser_out_settle_timer
    import phaser_out_tap_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             done
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            // Count load_val-1..0 so that done lands in the load_val-th cycle.
            cnt_d = load_val - TMR_W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/phaser_out_tap_ctrl.sv
// Purpose: turns single-beat tap requests into spaced one-cycle PHASER_OUT strobes and keeps shadow taps.
// Latency: N steps -> DONE at 2+N*(1+SETTLE_CYCLES); count 0 and LOAD -> 2; READ -> 2+READ_WAIT.
// Backpressure: REQ_READY only in IDLE; one request in flight, next accept the cycle after DONE.
// Ports: SYSCLK/RST; REQ_* request channel; DONE/RSP_VAL/RSP_OVF response; FINE_TAP/COARSE_TAP shadow
//        taps; FINE*/COARSE*/COUNTER* pins to the phaser and FINEOVERFLOW/COARSEOVERFLOW from it.
// Build option: PHASER_OUT_TAP_OVF_ABORT_EN makes phaser overflow flags seen during SETTLE abort the sequence.
module phaser_out_tap_ctrl
    import phaser_out_tap_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned READ_WAIT     = 4,
    parameter int unsigned FINE_INIT     = 0,
    parameter int unsigned COARSE_INIT   = 0
) (
    input  logic             SYSCLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_CMD,
    input  logic             REQ_INC,
    input  logic [TAP_W-1:0] REQ_COUNT,
    input  logic [CNT_W-1:0] REQ_LOADVAL,
    output logic             DONE,
    output logic [CNT_W-1:0] RSP_VAL,
    output logic             RSP_OVF,
    output logic [TAP_W-1:0] FINE_TAP,
    output logic [TAP_W-1:0] COARSE_TAP,
    output logic             FINEENABLE,
    output logic             FINEINC,
    output logic             COARSEENABLE,
    output logic             COARSEINC,
    output logic             COUNTERLOADEN,
    output logic [CNT_W-1:0] COUNTERLOADVAL,
    output logic             COUNTERREADEN,
    input  logic [CNT_W-1:0] COUNTERREADVAL,
    input  logic             FINEOVERFLOW,
    input  logic             COARSEOVERFLOW
);

    localparam logic [TAP_W-1:0] FINE_INIT_V   = TAP_W'(FINE_INIT);
    localparam logic [TAP_W-1:0] COARSE_INIT_V = TAP_W'(COARSE_INIT);
    localparam logic [TMR_W-1:0] SETTLE_LD     = TMR_W'(SETTLE_CYCLES);
    // The wait after the final pulse is one cycle longer than the inter-step gap,
    // giving the phaser a full settle window plus one before completion is reported.
    localparam logic [TMR_W-1:0] SETTLE_LAST_LD = TMR_W'(SETTLE_CYCLES + 1);
    // The read strobe occupies the first RDWAIT cycle; capture READ_WAIT cycles later.
    localparam logic [TMR_W-1:0] RD_LD          = TMR_W'(READ_WAIT + 1);

    state_e           state_q, state_d;
    cmd_e             cmd_q, cmd_d;
    logic             inc_q, inc_d;
    logic [TAP_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] loadval_q, loadval_d;
    logic [CNT_W-1:0] rsp_val_q, rsp_val_d;
    logic             ovf_q, ovf_d;
    logic             rd_en_q, rd_en_d;
    logic [TAP_W-1:0] fine_q, fine_d;
    logic [TAP_W-1:0] coarse_q, coarse_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    logic [TAP_W-1:0] req_tap;
    logic [TAP_W-1:0] cur_tap;

`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
    logic abort_q, abort_d;
    logic abort_now;
    assign abort_now = abort_q | ((cmd_q == CMD_COARSE) ? COARSEOVERFLOW : FINEOVERFLOW);
`else
    logic unused_ovf;
    assign unused_ovf = FINEOVERFLOW | COARSEOVERFLOW;
`endif

    assign req_tap = (cmd_e'(REQ_CMD) == CMD_COARSE) ? coarse_q : fine_q;
    assign cur_tap = (cmd_q == CMD_COARSE) ? coarse_q : fine_q;

    phaser_out_settle_timer u_timer (
        .clk      (SYSCLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        inc_d     = inc_q;
        rem_d     = rem_q;
        loadval_d = loadval_q;
        rsp_val_d = rsp_val_q;
        ovf_d     = ovf_q;
        rd_en_d   = 1'b0;
        fine_d    = fine_q;
        coarse_d  = coarse_q;
        tmr_load  = 1'b0;
        tmr_val   = SETTLE_LD;
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
        abort_d   = abort_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    cmd_d     = cmd_e'(REQ_CMD);
                    inc_d     = REQ_INC;
                    rem_d     = REQ_COUNT;
                    loadval_d = REQ_LOADVAL;
                    ovf_d     = 1'b0;
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
                    abort_d   = 1'b0;
`endif
                    case (cmd_e'(REQ_CMD))
                        CMD_LOAD: state_d = ST_LOAD;
                        CMD_READ: begin
                            state_d  = ST_RDWAIT;
                            rd_en_d  = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = RD_LD;
                        end
                        default: begin
                            if ((REQ_COUNT != '0) && step_ok(req_tap, REQ_INC)) begin
                                state_d = ST_PULSE;
                            end else begin
                                // No pulse: spend one wait cycle so completion timing
                                // matches the count-0 case; a blocked first step flags overflow.
                                state_d  = ST_SETTLE;
                                rem_d    = '0;
                                ovf_d    = (REQ_COUNT != '0);
                                tmr_load = 1'b1;
                                tmr_val  = TMR_W'(1);
                            end
                        end
                    endcase
                end
            end

            ST_PULSE: begin
                if (cmd_q == CMD_COARSE) begin
                    coarse_d = inc_q ? coarse_q + TAP_W'(1) : coarse_q - TAP_W'(1);
                end else begin
                    fine_d = inc_q ? fine_q + TAP_W'(1) : fine_q - TAP_W'(1);
                end
                rem_d    = rem_q - TAP_W'(1);
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = (rem_q == TAP_W'(1)) ? SETTLE_LAST_LD : SETTLE_LD;
            end

            ST_SETTLE: begin
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
                abort_d = abort_now;
`endif
                if (tmr_done) begin
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
                    if (abort_now) begin
                        state_d = ST_FIN;
                        ovf_d   = 1'b1;
                    end else
`endif
                    if (rem_q == '0) begin
                        state_d = ST_FIN;
                    end else if (step_ok(cur_tap, inc_q)) begin
                        state_d = ST_PULSE;
                    end else begin
                        state_d = ST_FIN;
                        ovf_d   = 1'b1;
                    end
                end
            end

            ST_LOAD: state_d = ST_FIN;

            ST_RDWAIT: begin
                if (tmr_done) begin
                    rsp_val_d = COUNTERREADVAL;
                    state_d   = ST_FIN;
                end
            end

            ST_FIN: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_FINE;
            inc_q     <= 1'b0;
            rem_q     <= '0;
            loadval_q <= '0;
            rsp_val_q <= '0;
            ovf_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            fine_q    <= FINE_INIT_V;
            coarse_q  <= COARSE_INIT_V;
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
            abort_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            inc_q     <= inc_d;
            rem_q     <= rem_d;
            loadval_q <= loadval_d;
            rsp_val_q <= rsp_val_d;
            ovf_q     <= ovf_d;
            rd_en_q   <= rd_en_d;
            fine_q    <= fine_d;
            coarse_q  <= coarse_d;
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
            abort_q   <= abort_d;
`endif
        end
    end

    assign REQ_READY      = (state_q == ST_IDLE);
    assign DONE           = (state_q == ST_FIN);
    assign RSP_VAL        = rsp_val_q;
    assign RSP_OVF        = ovf_q;
    assign FINE_TAP       = fine_q;
    assign COARSE_TAP     = coarse_q;
    assign FINEENABLE     = (state_q == ST_PULSE) && (cmd_q == CMD_FINE);
    assign COARSEENABLE   = (state_q == ST_PULSE) && (cmd_q == CMD_COARSE);
    assign FINEINC        = (state_q != ST_IDLE) && (cmd_q == CMD_FINE) && inc_q;
    assign COARSEINC      = (state_q != ST_IDLE) && (cmd_q == CMD_COARSE) && inc_q;
    assign COUNTERLOADEN  = (state_q == ST_LOAD);
    assign COUNTERLOADVAL = loadval_q;
    assign COUNTERREADEN  = rd_en_q;

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
module tb_phaser_out_tap_ctrl;

    localparam int SETTLE = 8;
    localparam int RWAIT  = 4;
    localparam int FINIT  = 10;
    localparam int CINIT  = 2;

    logic       SYSCLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_CMD = 2'd0;
    logic       REQ_INC = 1'b0;
    logic [5:0] REQ_COUNT = 6'd0;
    logic [8:0] REQ_LOADVAL = 9'd0;
    logic       DONE;
    logic [8:0] RSP_VAL;
    logic       RSP_OVF;
    logic [5:0] FINE_TAP, COARSE_TAP;
    logic       FINEENABLE, FINEINC, COARSEENABLE, COARSEINC;
    logic       COUNTERLOADEN, COUNTERREADEN;
    logic [8:0] COUNTERLOADVAL;
    logic [8:0] COUNTERREADVAL = 9'd0;
    logic       FINEOVERFLOW = 1'b0;
    logic       COARSEOVERFLOW = 1'b0;

    always #5 SYSCLK = ~SYSCLK;

    phaser_out_tap_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .READ_WAIT     (RWAIT),
        .FINE_INIT     (FINIT),
        .COARSE_INIT   (CINIT)
    ) dut (
        .SYSCLK         (SYSCLK),
        .RST            (RST),
        .REQ_VALID      (REQ_VALID),
        .REQ_READY      (REQ_READY),
        .REQ_CMD        (REQ_CMD),
        .REQ_INC        (REQ_INC),
        .REQ_COUNT      (REQ_COUNT),
        .REQ_LOADVAL    (REQ_LOADVAL),
        .DONE           (DONE),
        .RSP_VAL        (RSP_VAL),
        .RSP_OVF        (RSP_OVF),
        .FINE_TAP       (FINE_TAP),
        .COARSE_TAP     (COARSE_TAP),
        .FINEENABLE     (FINEENABLE),
        .FINEINC        (FINEINC),
        .COARSEENABLE   (COARSEENABLE),
        .COARSEINC      (COARSEINC),
        .COUNTERLOADEN  (COUNTERLOADEN),
        .COUNTERLOADVAL (COUNTERLOADVAL),
        .COUNTERREADEN  (COUNTERREADEN),
        .COUNTERREADVAL (COUNTERREADVAL),
        .FINEOVERFLOW   (FINEOVERFLOW),
        .COARSEOVERFLOW (COARSEOVERFLOW)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Observations from the most recent request, cycle 1 = first cycle after accept.
    int         n_fe, n_ce, n_le, n_re, multi, inc_bad;
    int         ld_cyc, re_cyc, done_cyc;
    logic [8:0] ld_val, val_done;
    logic       ovf_done;
    int         p_cyc[$];

    // Drives the request for the current cycle (caller sits at a negedge), then
    // watches up to budget cycles. rd_cyc: the only cycle COUNTERREADVAL carries 0x0F3.
    // ovf_from: FINEOVERFLOW is high from that cycle on (0 = never).
    task automatic issue(input logic [1:0] cmd, input logic inc, input logic [5:0] cnt,
                         input logic [8:0] lval, input int budget, input int rd_cyc,
                         input int ovf_from);
        REQ_CMD = cmd; REQ_INC = inc; REQ_COUNT = cnt; REQ_LOADVAL = lval; REQ_VALID = 1'b1;
        n_fe = 0; n_ce = 0; n_le = 0; n_re = 0; multi = 0; inc_bad = 0;
        ld_cyc = -1; re_cyc = -1; done_cyc = -1; ld_val = '0; val_done = '0; ovf_done = 1'b0;
        p_cyc.delete();
        for (int k = 1; k <= budget; k++) begin
            @(posedge SYSCLK);
            #1;
            REQ_VALID = 1'b0;
            COUNTERREADVAL = (k == rd_cyc) ? 9'h0F3 : 9'h111;
            FINEOVERFLOW = (ovf_from != 0) && (k >= ovf_from);
            @(negedge SYSCLK);
            if (FINEENABLE) begin n_fe++; p_cyc.push_back(k); if (FINEINC !== inc) inc_bad++; end
            if (COARSEENABLE) begin n_ce++; if (COARSEINC !== inc) inc_bad++; end
            if (COUNTERLOADEN) begin n_le++; ld_cyc = k; ld_val = COUNTERLOADVAL; end
            if (COUNTERREADEN) begin n_re++; re_cyc = k; end
            if (int'(FINEENABLE) + int'(COARSEENABLE) + int'(COUNTERLOADEN) + int'(COUNTERREADEN) > 1)
                multi++;
            if (DONE) begin
                done_cyc = k; ovf_done = RSP_OVF; val_done = RSP_VAL;
                break;
            end
        end
        FINEOVERFLOW = 1'b0;
        COUNTERREADVAL = 9'h000;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge SYSCLK);
        n_cmp++; if ({FINEENABLE, COARSEENABLE, COUNTERLOADEN, COUNTERREADEN, DONE} !== 5'b0) begin
            n_bad++; $display("FAIL rst_strobes_in_reset: got %b want 00000",
                {FINEENABLE, COARSEENABLE, COUNTERLOADEN, COUNTERREADEN, DONE}); end
        RST = 1'b0;
        @(negedge SYSCLK);
        n_cmp++; if (FINE_TAP !== 6'd10) begin n_bad++; $display("FAIL rst_fine_tap: got %0d want 10", FINE_TAP); end
        n_cmp++; if (COARSE_TAP !== 6'd2) begin n_bad++; $display("FAIL rst_coarse_tap: got %0d want 2", COARSE_TAP); end
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", REQ_READY); end
        n_cmp++; if ({FINEENABLE, FINEINC, COARSEENABLE, COARSEINC, COUNTERLOADEN, COUNTERREADEN, DONE, RSP_OVF} !== 8'b0) begin
            n_bad++; $display("FAIL rst_strobes: got %b want 00000000",
                {FINEENABLE, FINEINC, COARSEENABLE, COARSEINC, COUNTERLOADEN, COUNTERREADEN, DONE, RSP_OVF}); end
        n_cmp++; if ({RSP_VAL, COUNTERLOADVAL} !== 18'b0) begin
            n_bad++; $display("FAIL rst_values: got rsp=%h ldval=%h want 0 0", RSP_VAL, COUNTERLOADVAL); end
    endtask

    task automatic test_fine_step();
        issue(2'd0, 1'b1, 6'd3, 9'd0, 100, 0, 0);
        n_cmp++; if (n_fe !== 3) begin n_bad++; $display("FAIL fine_pulses: got %0d want 3", n_fe); end
        n_cmp++; if (p_cyc.size() != 3 || p_cyc[0] != 1 || p_cyc[1] != 10 || p_cyc[2] != 19) begin
            n_bad++; $display("FAIL fine_pulse_cycles: got %p want 1 10 19", p_cyc); end
        n_cmp++; if (done_cyc !== 29) begin n_bad++; $display("FAIL fine_done_cycle: got %0d want 29", done_cyc); end
        n_cmp++; if (FINE_TAP !== 6'd13) begin n_bad++; $display("FAIL fine_tap: got %0d want 13", FINE_TAP); end
        n_cmp++; if (ovf_done !== 1'b0) begin n_bad++; $display("FAIL fine_ovf: got %b want 0", ovf_done); end
        n_cmp++; if (inc_bad !== 0) begin n_bad++; $display("FAIL fine_inc_dir: got %0d bad want 0", inc_bad); end
        n_cmp++; if (n_ce + n_le + n_re + multi !== 0) begin
            n_bad++; $display("FAIL fine_other_strobes: got %0d want 0", n_ce + n_le + n_re + multi); end
        @(negedge SYSCLK);
        n_cmp++; if ({REQ_READY, FINEINC, DONE} !== 3'b100) begin
            n_bad++; $display("FAIL fine_idle_after: got %b want 100", {REQ_READY, FINEINC, DONE}); end
    endtask

    task automatic test_coarse_limit();
        issue(2'd1, 1'b0, 6'd5, 9'd0, 100, 0, 0);
        n_cmp++; if (n_ce !== 2) begin n_bad++; $display("FAIL coarse_pulses: got %0d want 2", n_ce); end
        n_cmp++; if (COARSE_TAP !== 6'd0) begin n_bad++; $display("FAIL coarse_tap: got %0d want 0", COARSE_TAP); end
        n_cmp++; if (done_cyc < 0) begin n_bad++; $display("FAIL coarse_done_seen: got %0d want >0", done_cyc); end
        n_cmp++; if (ovf_done !== 1'b1) begin n_bad++; $display("FAIL coarse_ovf: got %b want 1", ovf_done); end
        n_cmp++; if (n_fe + multi !== 0) begin n_bad++; $display("FAIL coarse_fine_strobes: got %0d want 0", n_fe + multi); end
        @(negedge SYSCLK);
    endtask

    task automatic test_load_read();
        issue(2'd2, 1'b0, 6'd0, 9'h1A5, 20, 0, 0);
        n_cmp++; if (n_le !== 1 || ld_cyc !== 1) begin
            n_bad++; $display("FAIL load_pulse: got n=%0d cyc=%0d want n=1 cyc=1", n_le, ld_cyc); end
        n_cmp++; if (ld_val !== 9'h1A5) begin n_bad++; $display("FAIL load_val: got %h want 1a5", ld_val); end
        n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL load_done_cycle: got %0d want 2", done_cyc); end
        n_cmp++; if (ovf_done !== 1'b0) begin n_bad++; $display("FAIL load_ovf_cleared: got %b want 0", ovf_done); end
        @(negedge SYSCLK);
        issue(2'd3, 1'b0, 6'd0, 9'd0, 20, 1 + RWAIT, 0);
        n_cmp++; if (n_re !== 1 || re_cyc !== 1) begin
            n_bad++; $display("FAIL read_strobe: got n=%0d cyc=%0d want n=1 cyc=1", n_re, re_cyc); end
        n_cmp++; if (done_cyc !== 2 + RWAIT) begin n_bad++; $display("FAIL read_done_cycle: got %0d want %0d", done_cyc, 2 + RWAIT); end
        n_cmp++; if (val_done !== 9'h0F3) begin n_bad++; $display("FAIL read_val: got %h want 0f3", val_done); end
        repeat (3) @(negedge SYSCLK);
        n_cmp++; if (RSP_VAL !== 9'h0F3) begin n_bad++; $display("FAIL read_val_held: got %h want 0f3", RSP_VAL); end
    endtask

    task automatic test_zero_count();
        issue(2'd0, 1'b1, 6'd0, 9'd0, 20, 0, 0);
        n_cmp++; if (done_cyc !== 2) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 2", done_cyc); end
        n_cmp++; if (n_fe !== 0 || ovf_done !== 1'b0) begin
            n_bad++; $display("FAIL zero_no_pulse: got n=%0d ovf=%b want 0 0", n_fe, ovf_done); end
        n_cmp++; if (FINE_TAP !== 6'd13) begin n_bad++; $display("FAIL zero_tap: got %0d want 13", FINE_TAP); end
        @(negedge SYSCLK);
    endtask

    task automatic test_overflow();
        issue(2'd0, 1'b0, 6'd6, 9'd0, 100, 0, 11);
`ifdef PHASER_OUT_TAP_OVF_ABORT_EN
        n_cmp++; if (n_fe !== 2) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 2", n_fe); end
        n_cmp++; if (ovf_done !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", ovf_done); end
        n_cmp++; if (FINE_TAP !== 6'd11) begin n_bad++; $display("FAIL ovf_tap: got %0d want 11", FINE_TAP); end
        n_cmp++; if (done_cyc !== 19) begin n_bad++; $display("FAIL ovf_done_cycle: got %0d want 19", done_cyc); end
`else
        n_cmp++; if (n_fe !== 6) begin n_bad++; $display("FAIL ovf_pulses: got %0d want 6", n_fe); end
        n_cmp++; if (ovf_done !== 1'b0) begin n_bad++; $display("FAIL ovf_flag: got %b want 0", ovf_done); end
        n_cmp++; if (FINE_TAP !== 6'd7) begin n_bad++; $display("FAIL ovf_tap: got %0d want 7", FINE_TAP); end
        n_cmp++; if (done_cyc !== 56) begin n_bad++; $display("FAIL ovf_done_cycle: got %0d want 56", done_cyc); end
`endif
    endtask

    task automatic test_back_to_back();
        // Still in the DONE cycle of the previous request.
        n_cmp++; if (REQ_READY !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_at_done: got %b want 0", REQ_READY); end
        @(negedge SYSCLK);
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after: got %b want 1", REQ_READY); end
        issue(2'd2, 1'b0, 6'd0, 9'h05A, 20, 0, 0);
        n_cmp++; if (done_cyc !== 2 || ld_val !== 9'h05A) begin
            n_bad++; $display("FAIL b2b_load: got done=%0d val=%h want 2 05a", done_cyc, ld_val); end
        @(negedge SYSCLK);
    endtask

    task automatic test_reset_mid();
        int dones;
        issue(2'd0, 1'b1, 6'd4, 9'd0, 5, 0, 0);
        n_cmp++; if (n_fe !== 1 || done_cyc !== -1) begin
            n_bad++; $display("FAIL mid_pre_reset: got n=%0d done=%0d want 1 -1", n_fe, done_cyc); end
        RST = 1'b1;
        dones = 0;
        repeat (3) begin
            @(negedge SYSCLK);
            if (DONE) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", dones); end
        n_cmp++; if (FINE_TAP !== 6'd10 || COARSE_TAP !== 6'd2) begin
            n_bad++; $display("FAIL mid_taps_init: got %0d/%0d want 10/2", FINE_TAP, COARSE_TAP); end
        n_cmp++; if (REQ_READY !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", REQ_READY); end
        RST = 1'b0;
        issue(2'd2, 1'b0, 6'd0, 9'h0C3, 20, 0, 0);
        n_cmp++; if (done_cyc !== 2 || ld_cyc !== 1 || ld_val !== 9'h0C3) begin
            n_bad++; $display("FAIL mid_accept_after_rst: got done=%0d ld=%0d val=%h want 2 1 0c3",
                done_cyc, ld_cyc, ld_val); end
    endtask

    initial begin
        test_reset();
        test_fine_step();
        test_coarse_limit();
        test_load_read();
        test_zero_count();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge SYSCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
